// File: rtl/solar_adc_seq.sv
// ---------------------------------------------------------------------------
// solar_adc_seq
// Time-multiplexes one shared 8-bit ADC across the four light sensors
// (N, E, S, W) of the solar tracker. For each channel, the sequencer:
//   1. drives the analog mux select,
//   2. waits SETTLE_CYC cycles for the mux to settle,
//   3. issues a one-cycle conversion start,
//   4. waits for the ADC done strobe, for at most TIMEOUT_CYC cycles.
// Results go into per-channel shadow registers. All four outputs are
// published together, only when a frame completes.
//
// Parameters
//   SETTLE_CYC  : mux settling cycles before each start (1..255)
//   TIMEOUT_CYC : maximum WAIT cycles per conversion (1..255)
//
// Ports
//   clk         : clock, all state changes on its rising edge
//   rst         : synchronous active-high reset, overrides every input
//   en          : enable continuous frame sampling
//   err_clr     : clear the sticky timeout flag
//   adc_data    : conversion result, valid with adc_done
//   adc_done    : one-cycle conversion-complete strobe
//   adc_sel     : analog mux select (0=N 1=E 2=S 3=W)
//   adc_start   : one-cycle conversion start pulse
//   lsn/lse/lss/lsw : last complete frame of sensor values
//   frame_valid : one-cycle pulse when lsn..lsw update
//   busy        : sequencer not idle
//   timeout_err : sticky conversion-timeout flag
// ---------------------------------------------------------------------------
module solar_adc_seq #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       err_clr,
  input  logic [7:0] adc_data,
  input  logic       adc_done,
  output logic [1:0] adc_sel,
  output logic       adc_start,
  output logic [7:0] lsn,
  output logic [7:0] lse,
  output logic [7:0] lss,
  output logic [7:0] lsw,
  output logic       frame_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam int DATA_W = 8;

  // The settle counter counts down to zero. The wait counter counts up
  // to the index of the last permitted WAIT cycle.
  localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_START  = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_ch;
  logic [7:0]        r_settle_cnt;
  logic [7:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_shadow [4];
  logic [DATA_W-1:0] r_lsn;
  logic [DATA_W-1:0] r_lse;
  logic [DATA_W-1:0] r_lss;
  logic [DATA_W-1:0] r_lsw;
  logic              r_frame_valid;
  logic              r_timeout_err;

  logic              w_start;
  logic              w_busy;
  logic              w_capture;
  logic              w_timeout;
  logic              w_complete;
  logic              w_publish;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and per-state strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_busy      = 1'b1;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_complete  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (en) begin
          w_state_nxt = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (r_settle_cnt == 8'd0) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        // Done is tested first, so a done strobe in the last permitted
        // cycle counts as a success rather than a timeout.
        if (adc_done) begin
          w_capture  = 1'b1;
          w_complete = 1'b1;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          w_timeout  = 1'b1;
          w_complete = 1'b1;
        end

        // A frame in progress always runs to channel 3, whatever en does.
        // en is consulted only at a frame boundary.
        if (w_complete) begin
          if ((r_ch != 2'd3) || en) begin
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_publish = w_complete && (r_ch == 2'd3);
  end

  // -------------------------------------------------------------------------
  // Counters, channel index, shadow capture, frame publication, error flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch          <= 2'd0;
      r_settle_cnt  <= SETTLE_LOAD;
      r_wait_cnt    <= 8'd0;
      r_shadow[0]   <= '0;
      r_shadow[1]   <= '0;
      r_shadow[2]   <= '0;
      r_shadow[3]   <= '0;
      r_lsn         <= '0;
      r_lse         <= '0;
      r_lss         <= '0;
      r_lsw         <= '0;
      r_frame_valid <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_valid <= w_publish;

      // The settle counter is preloaded whenever the sequencer is outside
      // SETTLE, so each entry to SETTLE starts from a full count.
      if (r_state != S_SETTLE) begin
        r_settle_cnt <= SETTLE_LOAD;
      end else if (r_settle_cnt != 8'd0) begin
        r_settle_cnt <= r_settle_cnt - 8'd1;
      end

      if (r_state != S_WAIT) begin
        r_wait_cnt <= 8'd0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      // The channel index wraps from 3 back to 0, so it is already 0 when
      // the next frame (or IDLE) begins.
      if (w_complete) begin
        r_ch <= r_ch + 2'd1;
      end

      if (w_capture) begin
        r_shadow[r_ch] <= adc_data;
      end

      // shadow[3] would only be written on this same edge, so the data for
      // the final channel is taken straight from the ADC bus.
      if (w_publish) begin
        r_lsn <= r_shadow[0];
        r_lse <= r_shadow[1];
        r_lss <= r_shadow[2];
        r_lsw <= w_capture ? adc_data : r_shadow[3];
      end

      // A timeout in the same cycle as err_clr leaves the flag set.
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (err_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign adc_sel     = r_ch;
  assign adc_start   = w_start;
  assign busy        = w_busy;
  assign lsn         = r_lsn;
  assign lse         = r_lse;
  assign lss         = r_lss;
  assign lsw         = r_lsw;
  assign frame_valid = r_frame_valid;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_solar_adc_seq.sv
module tb_solar_adc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       err_clr;
  logic [7:0] adc_data;
  logic       adc_done;
  logic [1:0] adc_sel;
  logic       adc_start;
  logic [7:0] lsn, lse, lss, lsw;
  logic       frame_valid;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  // ADC model: per-channel response delay in WAIT cycles (0 = never answers)
  int         m_dly [4];
  logic [7:0] m_val [4];
  int         m_cnt;
  logic [1:0] m_ch;
  int         inj_seq = 0;
  int         inj_seen = 0;
  logic [7:0] inj_data = 8'd0;

  solar_adc_seq #(
    .SETTLE_CYC (4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .err_clr    (err_clr),
    .adc_data   (adc_data),
    .adc_done   (adc_done),
    .adc_sel    (adc_sel),
    .adc_start  (adc_start),
    .lsn        (lsn),
    .lse        (lse),
    .lss        (lss),
    .lsw        (lsw),
    .frame_valid(frame_valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ADC model, driven on the falling edge
  initial begin
    adc_done = 1'b0;
    adc_data = 8'd0;
    m_cnt    = 0;
    m_ch     = 2'd0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          adc_done = 1'b1;
          adc_data = m_val[m_ch];
        end
      end
      if (adc_start === 1'b1) begin
        m_ch  = adc_sel;
        m_cnt = m_dly[adc_sel];
      end
      if (inj_seq != inj_seen) begin
        inj_seen = inj_seq;
        adc_done = 1'b1;
        adc_data = inj_data;
      end
      if (rst === 1'b1) m_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_model(input int d0, d1, d2, d3,
                           input logic [7:0] v0, v1, v2, v3);
    m_dly[0] = d0; m_dly[1] = d1; m_dly[2] = d2; m_dly[3] = d3;
    m_val[0] = v0; m_val[1] = v1; m_val[2] = v2; m_val[3] = v3;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; en = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_start(input logic [1:0] sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (adc_start === 1'b1 && adc_sel === sel) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fv(input int limit, output int cyc);
    cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (frame_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; en = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({adc_sel, adc_start, frame_valid, busy, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got sel=%0d start=%0b fv=%0b busy=%0b terr=%0b want all 0",
               adc_sel, adc_start, frame_valid, busy, timeout_err);
    end
    checks++;
    if ({lsn, lse, lss, lsw} !== 32'h0) begin
      errors++;
      $display("FAIL reset_ls got %0d/%0d/%0d/%0d want 0/0/0/0", lsn, lse, lss, lsw);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold busy got %0b want 0", busy);
    end
  endtask

  task automatic test_first_frame;
    int starts;
    int fv_cyc;
    set_model(1, 1, 1, 1, 8'd10, 8'd20, 8'd30, 8'd40);
    starts = 0;
    fv_cyc = 0;
    @(negedge clk);
    en = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (adc_start === 1'b1) starts++;
      if (cyc == 3) begin
        checks++;
        if (busy !== 1'b1 || adc_sel !== 2'd0) begin
          errors++;
          $display("FAIL settle_ch0 got busy=%0b sel=%0d want 1/0", busy, adc_sel);
        end
      end
      if (cyc == 7) begin
        checks++;
        if (adc_sel !== 2'd1) begin
          errors++;
          $display("FAIL ch1_sel got %0d want 1", adc_sel);
        end
      end
      if (frame_valid === 1'b1) begin
        fv_cyc = cyc;
        break;
      end
    end
    checks++;
    if (fv_cyc != 25) begin
      errors++;
      $display("FAIL frame_latency got %0d want 25", fv_cyc);
    end
    checks++;
    if (starts != 4) begin
      errors++;
      $display("FAIL start_count got %0d want 4", starts);
    end
    checks++;
    if ({lsn, lse, lss, lsw} !== {8'd10, 8'd20, 8'd30, 8'd40}) begin
      errors++;
      $display("FAIL frame1_ls got %0d/%0d/%0d/%0d want 10/20/30/40", lsn, lse, lss, lsw);
    end
  endtask

  // Continues straight from the first frame with en still high
  task automatic test_atomic;
    int fv_cyc;
    fv_cyc = 0;
    m_val[0] = 8'd50;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (frame_valid === 1'b1) begin
        fv_cyc = cyc;
        break;
      end
      checks++;
      if ({lsn, lse, lss, lsw} !== {8'd10, 8'd20, 8'd30, 8'd40}) begin
        errors++;
        $display("FAIL hold_ls cyc=%0d got %0d/%0d/%0d/%0d want 10/20/30/40",
                 cyc, lsn, lse, lss, lsw);
      end
    end
    checks++;
    if (fv_cyc != 24) begin
      errors++;
      $display("FAIL frame_period got %0d want 24", fv_cyc);
    end
    checks++;
    if ({lsn, lse, lss, lsw} !== {8'd50, 8'd20, 8'd30, 8'd40}) begin
      errors++;
      $display("FAIL frame2_ls got %0d/%0d/%0d/%0d want 50/20/30/40", lsn, lse, lss, lsw);
    end
    do_reset();
  endtask

  task automatic test_timeout;
    bit ok;
    int fv_cyc;
    set_model(1, 1, 1, 1, 8'd1, 8'd2, 8'd3, 8'd4);
    @(negedge clk);
    en = 1'b1;
    wait_fv(40, fv_cyc);
    checks++;
    if (fv_cyc == 0 || {lsn, lse, lss, lsw} !== {8'd1, 8'd2, 8'd3, 8'd4}) begin
      errors++;
      $display("FAIL to_prime got fv_cyc=%0d ls=%0d/%0d/%0d/%0d want 1/2/3/4",
               fv_cyc, lsn, lse, lss, lsw);
    end
    set_model(1, 0, 1, 1, 8'd5, 8'd6, 8'd7, 8'd8);
    wait_start(2'd1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_start_ch1 got no start want start on sel=1");
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_early got terr=%0b want 0 in 8th WAIT", timeout_err);
    end
    @(posedge clk); #1;
    checks++;
    if (timeout_err !== 1'b1 || adc_sel !== 2'd2) begin
      errors++;
      $display("FAIL to_set got terr=%0b sel=%0d want 1/2", timeout_err, adc_sel);
    end
    wait_fv(40, fv_cyc);
    checks++;
    if (fv_cyc == 0 || {lsn, lse, lss, lsw} !== {8'd5, 8'd2, 8'd7, 8'd8}) begin
      errors++;
      $display("FAIL to_frame got fv_cyc=%0d ls=%0d/%0d/%0d/%0d want 5/2/7/8",
               fv_cyc, lsn, lse, lss, lsw);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got terr=%0b want 0", timeout_err);
    end
    // Keep err_clr high through the next ch1 timeout: the timeout must win
    wait_start(2'd1, ok);
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (!ok || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_vs_clr got ok=%0b terr=%0b want 1/1", ok, timeout_err);
    end
    @(negedge clk);
    err_clr = 1'b0;
    do_reset();
  endtask

  task automatic test_done_priority;
    int fv_cyc;
    fv_cyc = 0;
    set_model(8, 1, 1, 1, 8'd77, 8'd21, 8'd33, 8'd44);
    @(negedge clk);
    en = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 15) begin
        inj_data = 8'd99;
        inj_seq++;
      end
      if (frame_valid === 1'b1) begin
        fv_cyc = cyc;
        break;
      end
    end
    checks++;
    if (fv_cyc != 32) begin
      errors++;
      $display("FAIL dp_latency got %0d want 32", fv_cyc);
    end
    checks++;
    if ({lsn, lse, lss, lsw} !== {8'd77, 8'd21, 8'd33, 8'd44}) begin
      errors++;
      $display("FAIL dp_ls got %0d/%0d/%0d/%0d want 77/21/33/44", lsn, lse, lss, lsw);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL dp_terr got %0b want 0", timeout_err);
    end
    do_reset();
  endtask

  task automatic test_en_drop;
    bit ok;
    int fvn;
    logic busy_at_fv;
    logic [31:0] ls_at_fv;
    fvn = 0;
    busy_at_fv = 1'b1;
    ls_at_fv = 32'h0;
    set_model(1, 1, 1, 1, 8'd11, 8'd22, 8'd33, 8'd44);
    @(negedge clk);
    en = 1'b1;
    wait_start(2'd1, ok);
    @(posedge clk); #1;
    @(negedge clk);
    en = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (frame_valid === 1'b1) begin
        fvn++;
        busy_at_fv = busy;
        ls_at_fv = {lsn, lse, lss, lsw};
      end
    end
    checks++;
    if (!ok || fvn != 1) begin
      errors++;
      $display("FAIL en_drop_fv got ok=%0b pulses=%0d want 1/1", ok, fvn);
    end
    checks++;
    if (ls_at_fv !== {8'd11, 8'd22, 8'd33, 8'd44}) begin
      errors++;
      $display("FAIL en_drop_ls got %h want 0b16212c", ls_at_fv);
    end
    checks++;
    if (busy_at_fv !== 1'b0 || busy !== 1'b0 || adc_sel !== 2'd0) begin
      errors++;
      $display("FAIL en_drop_idle got busy_fv=%0b busy=%0b sel=%0d want 0/0/0",
               busy_at_fv, busy, adc_sel);
    end
  endtask

  task automatic test_rst_mid_frame;
    bit ok;
    int fv_cyc;
    ok = 1'b0;
    set_model(1, 1, 1, 1, 8'd1, 8'd2, 8'd3, 8'd4);
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (adc_sel === 2'd2) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!ok || {adc_sel, adc_start, frame_valid, busy, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl got ok=%0b sel=%0d start=%0b fv=%0b busy=%0b terr=%0b want 1 then 0s",
               ok, adc_sel, adc_start, frame_valid, busy, timeout_err);
    end
    checks++;
    if ({lsn, lse, lss, lsw} !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_ls got %0d/%0d/%0d/%0d want 0/0/0/0", lsn, lse, lss, lsw);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_priority got busy=%0b fv=%0b want 0/0", busy, frame_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    set_model(0, 1, 1, 1, 8'd5, 8'd6, 8'd7, 8'd8);
    wait_fv(80, fv_cyc);
    checks++;
    if (fv_cyc == 0 || {lsn, lse, lss, lsw} !== {8'd0, 8'd6, 8'd7, 8'd8}) begin
      errors++;
      $display("FAIL shadow_discard got fv_cyc=%0d ls=%0d/%0d/%0d/%0d want 0/6/7/8",
               fv_cyc, lsn, lse, lss, lsw);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL shadow_discard_terr got %0b want 1", timeout_err);
    end
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    err_clr = 1'b0;
    set_model(1, 1, 1, 1, 8'd0, 8'd0, 8'd0, 8'd0);
    test_reset();
    test_first_frame();
    test_atomic();
    test_timeout();
    test_done_priority();
    test_en_drop();
    test_rst_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/solar_adc_seq.md
SOLAR_ADC_SEQ -- requirements
Module: solar_adc_seq

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 4, meaning mux settling cycles before each conversion start (legal range 1-255).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning maximum WAIT cycles per conversion (legal range 1-255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: enables continuous frame sampling.
REQ-006 The block SHALL have port err_clr, input, 1 bit: clears the sticky timeout flag.
REQ-007 The block SHALL have port adc_data, input, 8 bits: conversion result, valid when adc_done=1.
REQ-008 The block SHALL have port adc_done, input, 1 bit: one-cycle conversion-complete strobe from the shared ADC.
REQ-009 The block SHALL have port adc_sel, output, 2 bits: analog mux select (0=N, 1=E, 2=S, 3=W).
REQ-010 The block SHALL have port adc_start, output, 1 bit: one-cycle conversion-start pulse.
REQ-011 The block SHALL have ports lsn, lse, lss, lsw, output, 8 bits each: last complete frame of sensor values, feeding the tracker's light-sensor inputs.
REQ-012 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when lsn..lsw update.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: sticky, set on any conversion timeout.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, START, WAIT; channel index ch (2 bits) drives adc_sel directly.
REQ-016 IDLE with en=1 SHALL go to SETTLE with ch=0 and settle counter loaded; IDLE with en=0 SHALL stay.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to START.
REQ-018 START SHALL last exactly one cycle with adc_start=1; adc_start SHALL be 0 in all other states.
REQ-019 WAIT SHALL begin in the cycle after START; adc_done sampled high in WAIT SHALL capture adc_data into shadow register [ch].
REQ-020 adc_done outside WAIT SHALL be ignored; adc_data SHALL never be captured outside WAIT.
REQ-021 WAIT with adc_done=0 for TIMEOUT_CYC consecutive cycles SHALL set timeout_err, leave shadow[ch] unchanged, and complete the channel.
REQ-022 adc_done=1 in the final permitted WAIT cycle SHALL count as success (done wins over timeout).
REQ-023 On channel completion with ch<3, ch SHALL increment and state SHALL go to SETTLE.
REQ-024 On completion with ch=3, lsn/lse/lss/lsw SHALL load shadow[0..3] (including the value just captured) and frame_valid SHALL be 1 in the following cycle only.
REQ-025 After ch=3 completion, the next state SHALL be SETTLE with ch=0 if en=1, else IDLE.
REQ-026 en deasserted mid-frame SHALL NOT abort; the frame SHALL finish and publish.
REQ-027 Outputs lsn..lsw SHALL change only on frame publication (atomic 4-value update); a timed-out channel publishes its previous value.
REQ-028 err_clr=1 SHALL clear timeout_err next cycle; a simultaneous timeout SHALL win (flag stays 1).
REQ-029 With adc_done returned in the first WAIT cycle, one channel SHALL take SETTLE_CYC+2 cycles and one frame 4*(SETTLE_CYC+2) cycles (24 at default).

Reset
REQ-030 rst=1 SHALL force state IDLE, ch=0, adc_sel=0, adc_start=0, frame_valid=0, busy=0, timeout_err=0, lsn=lse=lss=lsw=0, shadow registers 0.
REQ-031 rst mid-frame SHALL abort without frame_valid; partial shadow data SHALL be discarded; rst SHALL take priority over every other input.

Verification
REQ-032 Reset, en=1, ADC model answers in first WAIT cycle with N=10,E=20,S=30,W=40 -> adc_start pulses 4x, frame_valid at cycle 25 after en sampled, lsn=10,lse=20,lss=30,lsw=40.
REQ-033 Second frame with N=50 only changed -> lsn..lsw hold 10/20/30/40 until frame_valid, then become 50/20/30/40 simultaneously.
REQ-034 TIMEOUT_CYC=8, ADC never answers ch=1 -> timeout_err=1 after 8 WAIT cycles, lse keeps prior value, sequence continues to ch=2; err_clr then clears it.
REQ-035 adc_done injected during SETTLE and in the 8th WAIT cycle (TIMEOUT_CYC=8) -> first ignored, second captured, timeout_err stays 0.
REQ-036 en dropped during ch=1 WAIT -> frame completes, one frame_valid, then IDLE with busy=0; rst asserted during ch=2 -> all outputs 0, no frame_valid.
